// File: rtl/legendre_rom_arbiter_pkg.sv
// Shared constants and types for the Legendre ROM arbitration slice.
//   LEGENDRE_ADDR_W    : ROM word address width
//   LEGENDRE_DATA_W    : ROM word width
//   LEGENDRE_TAIL_ADDR : tail word address, passed through like any other address
//   CONFLICT_W         : width of the saturating conflict counter
package legendre_rom_arbiter_pkg;

    localparam int LEGENDRE_ADDR_W = 10;
    localparam int LEGENDRE_DATA_W = 16;
    localparam logic [LEGENDRE_ADDR_W-1:0] LEGENDRE_TAIL_ADDR = 10'd640;
    localparam int CONFLICT_W = 16;

    typedef logic [LEGENDRE_ADDR_W-1:0] legendre_addr_t;
    typedef logic [LEGENDRE_DATA_W-1:0] legendre_word_t;
    typedef logic [CONFLICT_W-1:0]      conflict_cnt_t;

    localparam conflict_cnt_t CONFLICT_MAX = '1;

endpackage

// File: rtl/legendre_rom_arbiter_rr_pick.sv
// m_rr_pick: cyclic first-set search of an R-bit request vector starting at
// ptr_i (inclusive).
//   req_i    : request vector
//   ptr_i    : search start position
//   onehot_o : one-hot winner, 0 when no request
//   index_o  : winner index, 0 when no request
//   valid_o  : at least one request present
module m_rr_pick #(
    parameter int R  = 8,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [R-1:0]  onehot_o,
    output logic [PW-1:0] index_o,
    output logic          valid_o
);

    logic [2*R-1:0] dbl;
    logic [2*R-1:0] masked;
    logic [PW-1:0]  idx;
    logic           found;

    // Lower copy is masked below the pointer; the unmasked upper copy supplies
    // the wrap-around candidates, so a plain LSB-first scan gives cyclic order.
    always_comb begin
        dbl    = {req_i, req_i};
        masked = '0;
        for (int i = 0; i < 2*R; i++) begin
            masked[i] = dbl[i] & (i >= int'(ptr_i));
        end
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 2*R; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                idx   = PW'(i % R);
            end
        end
    end

    always_comb begin
        onehot_o = '0;
        if (found) begin
            onehot_o[idx] = 1'b1;
        end
    end

    assign index_o = idx;
    assign valid_o = found;

endmodule

// File: rtl/legendre_rom_arbiter.sv
// legendre_rom_arbiter: grants at most one Legendre ROM read per cycle among
// R = 2*CH_NUM requesters (r = 2*ch + k, k=0 sequence 1, k=1 sequence 2).
// Preempt-flagged requests beat normal ones; each class is round-robin.
//   clk, rst_b          : clock, synchronous active-low reset
//   enable              : 0 blocks all grants and freezes state
//   legendre_rd         : per-requester read request (level)
//   preempt             : per-requester priority flag, qualified by legendre_rd
//   legendre_addr       : packed per-requester addresses, 10 bits each
//   legendre_read_valid : one-hot grant, combinational
//   rom_rd, rom_addr    : ROM read strobe and address
//   rom_data            : ROM output, valid the cycle after rom_rd
//   legendre_data       : broadcast return data
//   conflict_count      : saturating count of cycles with >=2 active requests
module legendre_rom_arbiter
    import legendre_rom_arbiter_pkg::*;
#(
    parameter int CH_NUM = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_b,
    input  logic                                 enable,
    input  logic [2*CH_NUM-1:0]                  legendre_rd,
    input  logic [2*CH_NUM-1:0]                  preempt,
    input  logic [LEGENDRE_ADDR_W*2*CH_NUM-1:0]  legendre_addr,
    output logic [2*CH_NUM-1:0]                  legendre_read_valid,
    output logic                                 rom_rd,
    output logic [LEGENDRE_ADDR_W-1:0]           rom_addr,
    input  logic [LEGENDRE_DATA_W-1:0]           rom_data,
    output logic [LEGENDRE_DATA_W-1:0]           legendre_data,
    output logic [CONFLICT_W-1:0]                conflict_count
);

    localparam int R  = 2 * CH_NUM;
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req;
    logic [R-1:0]   hi;
    logic [R-1:0]   lo;
    logic [R-1:0]   hi_onehot;
    logic [R-1:0]   lo_onehot;
    logic [PW-1:0]  hi_idx;
    logic [PW-1:0]  lo_idx;
    logic           hi_valid;
    logic           lo_valid;
    logic [R-1:0]   grant;
    logic [PW-1:0]  winner;
    logic           granted;
    logic           multi_req;
    legendre_addr_t addr_mux;

    logic [PW-1:0]  ptr_hi_q, ptr_hi_d;
    logic [PW-1:0]  ptr_lo_q, ptr_lo_d;
    conflict_cnt_t  conflict_q, conflict_d;

    assign req = legendre_rd & {R{enable}};
    assign hi  = req & preempt;
    assign lo  = req & ~preempt;

    m_rr_pick #(.R(R), .PW(PW)) u_pick_hi (
        .req_i    (hi),
        .ptr_i    (ptr_hi_q),
        .onehot_o (hi_onehot),
        .index_o  (hi_idx),
        .valid_o  (hi_valid)
    );

    m_rr_pick #(.R(R), .PW(PW)) u_pick_lo (
        .req_i    (lo),
        .ptr_i    (ptr_lo_q),
        .onehot_o (lo_onehot),
        .index_o  (lo_idx),
        .valid_o  (lo_valid)
    );

    assign grant   = hi_valid ? hi_onehot : lo_onehot;
    assign winner  = hi_valid ? hi_idx : lo_idx;
    assign granted = hi_valid | lo_valid;

    // Grant is one-hot, so OR-ing the gated lanes is a clean mux and yields 0
    // when idle.
    always_comb begin
        addr_mux = '0;
        for (int r = 0; r < R; r++) begin
            if (grant[r]) begin
                addr_mux = addr_mux | legendre_addr[r*LEGENDRE_ADDR_W +: LEGENDRE_ADDR_W];
            end
        end
    end

    assign legendre_read_valid = grant;
    assign rom_rd              = granted;
    assign rom_addr            = addr_mux;
    assign legendre_data       = rom_data;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_req = (req & (req - R'(1))) != '0;

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
        return (idx == PW'(R - 1)) ? '0 : idx + PW'(1);
    endfunction

    always_comb begin
        ptr_hi_d   = ptr_hi_q;
        ptr_lo_d   = ptr_lo_q;
        conflict_d = conflict_q;
        if (granted) begin
            if (hi_valid) begin
                ptr_hi_d = rr_next(winner);
            end else begin
                ptr_lo_d = rr_next(winner);
            end
        end
        if (multi_req && (conflict_q != CONFLICT_MAX)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ptr_hi_q   <= '0;
            ptr_lo_q   <= '0;
            conflict_q <= '0;
        end else begin
            ptr_hi_q   <= ptr_hi_d;
            ptr_lo_q   <= ptr_lo_d;
            conflict_q <= conflict_d;
        end
    end

    assign conflict_count = conflict_q;

endmodule

// File: doc/legendre_rom_arbiter.md
# legendre_rom_arbiter

Arbitrates the single-port Legendre sequence ROM (640 words × 16 bits, plus tail word 640) among all Weil PRN generators in the correlator array. Each generator presents two independent preload requesters: Legendre sequence 1 and sequence 2. The block grants at most one ROM read per clock and returns ROM data on a shared broadcast bus one cycle later. Preempt-flagged requests win over normal requests. Round-robin ordering within each class guarantees fairness.

## Interface
- CH_NUM, 4: number of Weil PRN generators. Requester count is R = 2·CH_NUM; requester index r = 2·ch + k, where k=0 is sequence 1 and k=1 is sequence 2.
- clk  in  1  system clock; single clock domain.
- rst_b  in  1  reset, synchronous, active-low.
- enable  in  1  arbitration enable; 0 blocks all grants.
- legendre_rd  in  R  per-requester read request; level, held until granted.
- preempt  in  R  per-requester priority flag; qualified by legendre_rd.
- legendre_addr  in  10·R  per-requester word address; requester r uses bits [10r+9:10r].
- legendre_read_valid  out  R  one-hot grant, combinational.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  10  ROM address.
- rom_data  in  16  ROM output, registered inside the ROM, valid the cycle after rom_rd.
- legendre_data  out  16  broadcast return data; equals rom_data.
- conflict_count  out  16  saturating count of cycles with more than one active request.

## Operation
- Active request: req[r] = legendre_rd[r] & enable.
- Priority class: hi[r] = req[r] & preempt[r]; lo[r] = req[r] & ~preempt[r].
- If any hi is set, the winner is the first set hi bit at or after ptr_hi, searching cyclically. Otherwise the winner is the first set lo bit at or after ptr_lo.
- Grant output: legendre_read_valid = onehot(winner), or 0 when there is no request.
- rom_rd = |legendre_read_valid; rom_addr = legendre_addr[winner], or 0 when idle.
- Pointer update happens only on a grant, and only for the winning class: ptr ← (winner+1) mod R. The other class pointer holds. Pointers are ceil(log2 R) bits wide.
- A requester drops legendre_rd on the cycle after its grant. The arbiter does not rely on this: a still-asserted request simply re-enters arbitration.
- conflict_count increments by 1 on every cycle where popcount(req) ≥ 2. It saturates at 0xFFFF.
- enable=0: no grants, rom_rd=0, pointers hold, conflict_count holds.
- preempt set while legendre_rd=0: ignored.
- Address 640 (tail word) is passed through unchanged. Substituting the tail value is the requester's job.

## Timing
- Reset (rst_b=0 at a clk edge) sets ptr_hi=0, ptr_lo=0, conflict_count=0.
- Grant outputs are combinational, so they are also 0 while reset is active and no request is present. Reset asserted mid-grant has no data side effect; the ROM return in the following cycle is simply unused.
- Request asserted in cycle T and won: legendre_read_valid[r]=1, rom_rd=1, rom_addr=addr in cycle T. Valid legendre_data appears in cycle T+1. The requester registers "read done" at the T edge and latches data at the T+1 edge.
- Throughput: one grant per cycle, with back-to-back grants to different requesters allowed.
- Worst-case wait for a lo request with no hi traffic: R−1 cycles.
- Worst-case wait for a hi request: R−1 cycles. lo requests can starve only under sustained hi traffic, which is bounded by the generators (preempt is static per phase setup).
- Simultaneous requests in a cycle resolve in that same cycle; there is no request latching.

## Structure
- Shared package entries: LEGENDRE_ADDR_W=10, LEGENDRE_DATA_W=16, LEGENDRE_TAIL_ADDR=10'd640.
- Sub-module m_rr_pick (parameter R): cyclic first-set search of an R-bit vector from a pointer. Outputs are a one-hot vector and an index.
  - Instantiated twice, once for hi and once for lo.
  - Implement as a double-width vector with the masked search.
- Top level contains: class select, address mux, pointer registers, conflict counter.

## Test plan
- Single request: r=3, addr=0x12A, preempt=0 → read_valid=0x08 in the same cycle; rom_addr=0x12A. Next cycle legendre_data equals ROM[0x12A]; ptr_lo becomes 4.
- All 8 lo requests held continuously after reset → grants in order 0,1,…,7,0. Exactly one grant per cycle; conflict_count increments every cycle.
- Mixed classes: lo on r=0,5 and hi on r=6 → r=6 granted first. Next cycle r=0, then r=5; ptr_hi=7 and ptr_lo=6 at the end.
- enable toggled to 0 while r=2 is pending → no read_valid and rom_rd=0 while disabled. r=2 is granted in the first cycle after enable returns to 1; pointers are unchanged across the gap.
- Reset mid-stream: after grants have advanced ptr_lo to 5, assert rst_b=0 for one cycle with all requests active → next grant is r=0 and conflict_count reads 0.
- Saturation: force 65540 conflict cycles → conflict_count holds at 0xFFFF.
